spi_minion_param: RTL and testbench
===================================

# spi_minion_param

Parametrised SPI minion with dual valid/ready FIFOs that bridges an off-chip SPI host to the on-chip valid/ready fabric (crossbars, classifier, wishbone-side adapters). This generation supports configurable payload width and FIFO depth, full-duplex frames that carry independent write and read requests, host-visible flow control, sticky error reporting and an optional parity output. It runs entirely in the system clock domain; SPI pins are oversampled through synchronisers.

## Interface
- DATA_W, 32: payload bits per frame; frame length PKT_W = DATA_W+2.
- DEPTH, 4: entries in each FIFO; power of 2, at least 2.

- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- cs  input  1  SPI chip select, active low.
- sclk  input  1  SPI clock, mode 0.
- mosi  input  1  SPI host-to-minion data, MSB first.
- miso  output  1  SPI minion-to-host data, MSB first.
- recv_msg  output  DATA_W  head of the RX FIFO, sent to the fabric.
- recv_val  output  1  RX FIFO is non-empty.
- recv_rdy  input  1  fabric accepts recv_msg.
- send_msg  input  DATA_W  data from the fabric into the TX FIFO.
- send_val  input  1  send_msg is valid.
- send_rdy  output  1  TX FIFO is not full.
- parity  output  1  XOR of recv_msg; see Configuration.
- overflow  output  1  sticky: a write was dropped.
- frame_err  output  1  sticky: a frame had the wrong bit count.

## Operation
- **Synchronisers.** cs, sclk and mosi each pass through 2 flops. A third flop on cs and on sclk provides edge detect. Reset values: cs=1, sclk=0, mosi=0.
- **MOSI frame.** {wr, rd, data[DATA_W-1:0]}.
- **MISO frame.** {rx_space, tx_val, tx_data}.
  - rx_space = RX FIFO not full.
  - tx_val = TX FIFO not empty.
  - tx_data = TX head, or 0 when the TX FIFO is empty.
- **cs falling edge.**
  - Load shift_out with the MISO frame.
  - Latch tx_val into tx_sent.
  - Clear bit_cnt.
- **sclk rising edge, cs low.** shift_in <= {shift_in, mosi}. bit_cnt increments and saturates at PKT_W+1.
- **sclk falling edge, cs low.** shift_out shifts left by 1.
- **miso output.** miso = shift_out[PKT_W-1] while cs is low; 0 while cs is high.
- **cs rising edge with bit_cnt==PKT_W (commit).**
  - If wr=1: push data if the RX FIFO is not full or is popped in the same cycle. Otherwise drop the data and set overflow.
  - If rd=1 and tx_sent=1: pop the TX FIFO.
  - A frame with wr=rd=0 is a no-op.
- **cs rising edge with bit_cnt!=PKT_W.** Discard the frame: no push, no pop. Set frame_err.
- **RX FIFO.** Pops on recv_val && recv_rdy.
- **TX FIFO.** Pushes on send_val && send_rdy. A fabric push and a commit pop in the same cycle are both honoured.
- **Pointers.** log2(DEPTH)+1 bits with wrap bit. Full = addresses equal and wrap bits differ. Empty = pointers equal.
- **Sticky flags.** overflow and frame_err clear only on reset.
- **Reset (asynchronous, any time including mid-frame).**
  - All registers clear: FIFOs empty, recv_msg=0, recv_val=0, miso=0, parity=0, overflow=0, frame_err=0, bit_cnt=0.
  - send_rdy=0 while reset is low; send_rdy=1 after release.
  - If cs is still low at release, the synchronised cs fall starts a partial frame, which ends in frame_err.

## Timing
- Synchroniser latency is 2 clk. Edge detect is combinational on the second and third flops; the resulting action registers at the next clk edge.
- A pin edge just before clk edge 1 takes effect at edge 3.
- recv_val rises after edge 3 following cs rising at the pin.
- send_rdy reflects a commit pop at the edge after edge 3.
- Each sclk high or low phase must last at least 3 clk periods.
- cs high time must be at least 4 clk periods between frames.
- miso changes 3 clk after the sclk fall at the pin, so it is valid before the next host sample.
- recv_msg and recv_val update the cycle after a pop or push. There is no bypass: an empty FIFO plus a push gives recv_val=1 one cycle later.

## Configuration
- SPI_MINION_PARITY_EN defined: parity is a register updated every cycle to ^recv_msg & recv_val, so it lags recv_msg by 1 clk.
- SPI_MINION_PARITY_EN undefined: parity is tied to 0 and no parity logic is built.

## Test plan
- **Write frame.** Defaults, MOSI {1,0,0xDEADBEEF}, recv_rdy=0 -> recv_val=1 and recv_msg=0xDEADBEEF 3 clk after cs rise; parity=0 with the macro. Repeat with 0x00000001 -> parity=1.
- **Read frame.** Push send_msg=0x12345678, then MOSI {0,1,0} -> MISO {1,1,0x12345678}, TX FIFO empty after commit. Second read -> MISO {1,0,0x00000000}, no pop.
- **Overflow.** recv_rdy=0, five write frames with data 1..5 -> FIFO holds 1,2,3,4; 5 dropped; overflow=1; rx_space=0 on the fifth frame's MISO. Then recv_rdy=1 -> 1,2,3,4 drain in order.
- **Short frame.** cs low, 20 sclk pulses, cs high -> no push, no pop, frame_err=1, FIFO contents unchanged.
- **Full duplex.** TX holds 0xA5A5A5A5, MOSI {1,1,0x0000BEEF}, RX full with recv_rdy=1 at commit -> 0x0000BEEF accepted, TX popped, overflow=0.
- **Reset mid-frame.** reset low after 10 sclk pulses -> all outputs at reset values, FIFOs empty. Release with cs low, then cs rise -> frame_err=1.

Source files
------------

// File: rtl/spi_minion_param.sv
// SPI minion (mode 0) bridging an off-chip host to valid/ready RX and TX FIFOs in the clk domain.
// Optional parity register on recv_msg is built when SPI_MINION_PARITY_EN is defined.
module spi_minion_param #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  output logic [DATA_W-1:0] recv_msg,
  output logic              recv_val,
  input  logic              recv_rdy,
  input  logic [DATA_W-1:0] send_msg,
  input  logic              send_val,
  output logic              send_rdy,
  output logic              parity,
  output logic              overflow,
  output logic              frame_err
);

  localparam int PKT_W = DATA_W + 2;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(PKT_W + 2);
  localparam logic [CW-1:0] CNT_FRAME = CW'(PKT_W);
  localparam logic [CW-1:0] CNT_MAX   = CW'(PKT_W + 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_ALMOST = (AW+1)'(DEPTH - 1);

  logic [2:0]              cs_sync_r;
  logic [2:0]              sclk_sync_r;
  logic [1:0]              mosi_sync_r;
  logic [PKT_W-1:0]        shift_in_r;
  logic [PKT_W-1:0]        shift_out_r;
  logic [CW-1:0]           bit_cnt_r;
  logic                    tx_sent_r;
  logic [DATA_W-1:0]       rx_mem_r [DEPTH];
  logic [DATA_W-1:0]       tx_mem_r [DEPTH];
  logic [AW:0]             rx_wr_ptr_r, rx_rd_ptr_r;
  logic [AW:0]             tx_wr_ptr_r, tx_rd_ptr_r;
  logic                    send_rdy_r;
  logic                    overflow_r;
  logic                    frame_err_r;

  logic                    cs_fall_s, cs_rise_s, cs_low_s;
  logic                    sclk_rise_s, sclk_fall_s, mosi_s;
  logic                    commit_s, frame_bad_s, wr_s, rd_s;
  logic                    rx_empty_s, rx_full_s, tx_empty_s, tx_full_s;
  logic                    rx_pop_s, rx_push_req_s, rx_push_s, rx_drop_s;
  logic                    tx_push_s, tx_pop_s, tx_val_s;
  logic [DATA_W-1:0]       tx_data_s;
  logic [AW:0]             tx_count_s;
  logic [PKT_W-1:0]        miso_frame_s;

  // Pin synchronisers; bit 0 is the first flop, bit 2 the edge-detect flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_sync_r   <= 3'b111;
      sclk_sync_r <= 3'b000;
      mosi_sync_r <= 2'b00;
    end else begin
      cs_sync_r   <= {cs_sync_r[1:0], cs};
      sclk_sync_r <= {sclk_sync_r[1:0], sclk};
      mosi_sync_r <= {mosi_sync_r[0], mosi};
    end
  end

  assign cs_fall_s   = ~cs_sync_r[1] &  cs_sync_r[2];
  assign cs_rise_s   =  cs_sync_r[1] & ~cs_sync_r[2];
  assign cs_low_s    = ~cs_sync_r[1];
  assign sclk_rise_s =  sclk_sync_r[1] & ~sclk_sync_r[2];
  assign sclk_fall_s = ~sclk_sync_r[1] &  sclk_sync_r[2];
  assign mosi_s      =  mosi_sync_r[1];

  assign rx_empty_s = (rx_wr_ptr_r == rx_rd_ptr_r);
  assign rx_full_s  = (rx_wr_ptr_r[AW-1:0] == rx_rd_ptr_r[AW-1:0]) &&
                      (rx_wr_ptr_r[AW] != rx_rd_ptr_r[AW]);
  assign tx_empty_s = (tx_wr_ptr_r == tx_rd_ptr_r);
  assign tx_full_s  = (tx_wr_ptr_r[AW-1:0] == tx_rd_ptr_r[AW-1:0]) &&
                      (tx_wr_ptr_r[AW] != tx_rd_ptr_r[AW]);
  assign tx_count_s = tx_wr_ptr_r - tx_rd_ptr_r;

  assign tx_val_s     = ~tx_empty_s;
  assign tx_data_s    = tx_empty_s ? {DATA_W{1'b0}} : tx_mem_r[tx_rd_ptr_r[AW-1:0]];
  assign miso_frame_s = {~rx_full_s, tx_val_s, tx_data_s};

  // Frame shifters and bit counter; cs fall snapshots the reply frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_in_r  <= {PKT_W{1'b0}};
      shift_out_r <= {PKT_W{1'b0}};
      bit_cnt_r   <= {CW{1'b0}};
      tx_sent_r   <= 1'b0;
    end else if (cs_fall_s) begin
      shift_out_r <= miso_frame_s;
      tx_sent_r   <= tx_val_s;
      bit_cnt_r   <= {CW{1'b0}};
    end else begin
      if (cs_low_s && sclk_rise_s) begin
        shift_in_r <= {shift_in_r[PKT_W-2:0], mosi_s};
        if (bit_cnt_r != CNT_MAX) begin
          bit_cnt_r <= bit_cnt_r + CNT_ONE;
        end else begin
          bit_cnt_r <= bit_cnt_r;
        end
      end else begin
        shift_in_r <= shift_in_r;
      end
      if (cs_low_s && sclk_fall_s) begin
        shift_out_r <= {shift_out_r[PKT_W-2:0], 1'b0};
      end else begin
        shift_out_r <= shift_out_r;
      end
    end
  end

  // Gated on the edge-detect flop so the freshly loaded frame is what appears first.
  assign miso = ~cs_sync_r[2] & shift_out_r[PKT_W-1];

  assign commit_s      = cs_rise_s && (bit_cnt_r == CNT_FRAME);
  assign frame_bad_s   = cs_rise_s && (bit_cnt_r != CNT_FRAME);
  assign wr_s          = shift_in_r[PKT_W-1];
  assign rd_s          = shift_in_r[PKT_W-2];
  assign rx_pop_s      = ~rx_empty_s & recv_rdy;
  assign rx_push_req_s = commit_s & wr_s;
  assign rx_push_s     = rx_push_req_s & (~rx_full_s | rx_pop_s);
  assign rx_drop_s     = rx_push_req_s & ~rx_push_s;
  assign tx_push_s     = send_val & send_rdy_r;
  assign tx_pop_s      = commit_s & rd_s & tx_sent_r & ~tx_empty_s;

  // RX FIFO storage and pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_wr_ptr_r <= {(AW+1){1'b0}};
      rx_rd_ptr_r <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) rx_mem_r[i] <= {DATA_W{1'b0}};
    end else begin
      if (rx_push_s) begin
        rx_mem_r[rx_wr_ptr_r[AW-1:0]] <= shift_in_r[DATA_W-1:0];
        rx_wr_ptr_r <= rx_wr_ptr_r + PTR_ONE;
      end
      if (rx_pop_s) begin
        rx_rd_ptr_r <= rx_rd_ptr_r + PTR_ONE;
      end
    end
  end

  // TX FIFO storage and pointers; fabric push and commit pop may coincide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wr_ptr_r <= {(AW+1){1'b0}};
      tx_rd_ptr_r <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) tx_mem_r[i] <= {DATA_W{1'b0}};
    end else begin
      if (tx_push_s) begin
        tx_mem_r[tx_wr_ptr_r[AW-1:0]] <= send_msg;
        tx_wr_ptr_r <= tx_wr_ptr_r + PTR_ONE;
      end
      if (tx_pop_s) begin
        tx_rd_ptr_r <= tx_rd_ptr_r + PTR_ONE;
      end
    end
  end

  // send_rdy drops in the same edge that fills the FIFO and rises one edge after space frees.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      send_rdy_r <= 1'b0;
    end else begin
      send_rdy_r <= ~(tx_full_s | (tx_push_s & (tx_count_s == CNT_ALMOST)));
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      overflow_r  <= overflow_r  | rx_drop_s;
      frame_err_r <= frame_err_r | frame_bad_s;
    end
  end

  assign recv_val  = ~rx_empty_s;
  assign recv_msg  = rx_empty_s ? {DATA_W{1'b0}} : rx_mem_r[rx_rd_ptr_r[AW-1:0]];
  assign send_rdy  = send_rdy_r;
  assign overflow  = overflow_r;
  assign frame_err = frame_err_r;

`ifdef SPI_MINION_PARITY_EN
  logic parity_r;

  // Parity of the RX head, one clk behind recv_msg.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_r <= 1'b0;
    end else begin
      parity_r <= (^recv_msg) & recv_val;
    end
  end

  assign parity = parity_r;
`else
  assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_spi_minion_param.sv
// Directed bench for spi_minion_param: bit-banged SPI host plus fabric-side pushes and pops.
module tb_spi_minion_param;

  localparam int DATA_W = 32;
  localparam int PKT_W  = DATA_W + 2;
`ifdef SPI_MINION_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset, cs, sclk, mosi, miso;
  logic [DATA_W-1:0] recv_msg, send_msg;
  logic              recv_val, recv_rdy, send_val, send_rdy;
  logic              parity, overflow, frame_err;
  logic [PKT_W-1:0]  rx;

  int err_cnt = 0;
  int chk_cnt = 0;

  spi_minion_param #(.DATA_W(DATA_W), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
    .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(recv_rdy),
    .send_msg(send_msg), .send_val(send_val), .send_rdy(send_rdy),
    .parity(parity), .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bits(input logic [PKT_W-1:0] frame, input int nbits,
                          output logic [PKT_W-1:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = frame[PKT_W-1-i];
      tick(4);
      got[PKT_W-1-i] = miso;
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
    mosi = 1'b0;
  endtask

  // Leaves cs just released; the caller decides how long to wait afterwards.
  task automatic spi_frame(input logic [PKT_W-1:0] frame, input int nbits,
                           output logic [PKT_W-1:0] got);
    cs = 1'b0;
    tick(5);
    spi_bits(frame, nbits, got);
    tick(4);
    cs = 1'b1;
  endtask

  task automatic push_tx(input logic [DATA_W-1:0] d);
    send_msg = d;
    send_val = 1'b1;
    tick(1);
    send_val = 1'b0;
  endtask

  task automatic pop_rx();
    recv_rdy = 1'b1;
    tick(1);
    recv_rdy = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] exp_q [4];
    reset = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    recv_rdy = 1'b0; send_val = 1'b0; send_msg = '0;
    tick(3);
    check_eq("rst_recv_val", 64'(recv_val), 64'd0);
    check_eq("rst_recv_msg", 64'(recv_msg), 64'd0);
    check_eq("rst_miso", 64'(miso), 64'd0);
    check_eq("rst_parity", 64'(parity), 64'd0);
    check_eq("rst_overflow", 64'(overflow), 64'd0);
    check_eq("rst_frame_err", 64'(frame_err), 64'd0);
    check_eq("rst_send_rdy", 64'(send_rdy), 64'd0);
    reset = 1'b1;
    tick(3);
    check_eq("send_rdy_release", 64'(send_rdy), 64'd1);

    // Write frame with exact commit latency
    spi_frame({2'b10, 32'hDEADBEEF}, PKT_W, rx);
    check_eq("wr_miso_frame", 64'(rx), 64'h2_0000_0000);
    tick(2);
    check_eq("wr_val_edge2", 64'(recv_val), 64'd0);
    tick(1);
    check_eq("wr_val_edge3", 64'(recv_val), 64'd1);
    check_eq("wr_msg", 64'(recv_msg), 64'hDEADBEEF);
    tick(2);
    check_eq("wr_parity0", 64'(parity), 64'd0);
    pop_rx();
    check_eq("wr_popped", 64'(recv_val), 64'd0);
    tick(4);
    spi_frame({2'b10, 32'h0000_0001}, PKT_W, rx);
    tick(6);
    check_eq("wr1_msg", 64'(recv_msg), 64'd1);
    check_eq("wr1_parity", 64'(parity), 64'(PAR_EN));
    pop_rx();
    tick(4);

    // Read frames
    push_tx(32'h12345678);
    tick(2);
    check_eq("tx_rdy_one", 64'(send_rdy), 64'd1);
    spi_frame({2'b01, 32'h0}, PKT_W, rx);
    check_eq("rd_miso_frame", 64'(rx), 64'h3_1234_5678);
    tick(6);
    check_eq("rd_no_push", 64'(recv_val), 64'd0);
    spi_frame({2'b01, 32'h0}, PKT_W, rx);
    check_eq("rd_empty_frame", 64'(rx), 64'h2_0000_0000);
    tick(6);

    // Full duplex into a full RX FIFO popped at the commit edge
    push_tx(32'hA5A5A5A5);
    for (int d = 10; d < 14; d++) begin
      spi_frame({2'b10, 32'(d)}, PKT_W, rx);
      tick(6);
    end
    spi_frame({2'b11, 32'h0000BEEF}, PKT_W, rx);
    check_eq("fd_miso_frame", 64'(rx), 64'h1_A5A5_A5A5);
    tick(2);
    recv_rdy = 1'b1;
    tick(1);
    recv_rdy = 1'b0;
    tick(3);
    check_eq("fd_overflow", 64'(overflow), 64'd0);
    exp_q = '{32'd11, 32'd12, 32'd13, 32'h0000BEEF};
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("fd_drain%0d", i), 64'(recv_msg), 64'(exp_q[i]));
      pop_rx();
    end
    check_eq("fd_drained", 64'(recv_val), 64'd0);

    // Overflow
    for (int d = 1; d < 6; d++) begin
      spi_frame({2'b10, 32'(d)}, PKT_W, rx);
      if (d == 1) check_eq("ovf_first_miso", 64'(rx), 64'h2_0000_0000);
      if (d == 5) check_eq("ovf_fifth_miso", 64'(rx), 64'h0);
      tick(6);
      if (d == 4) begin
        check_eq("ovf_before", 64'(overflow), 64'd0);
        check_eq("ferr_before", 64'(frame_err), 64'd0);
      end
    end
    check_eq("ovf_set", 64'(overflow), 64'd1);

    // Short frame leaves FIFO untouched
    spi_frame({2'b11, 32'hFFFFFFFF}, 20, rx);
    tick(6);
    check_eq("short_frame_err", 64'(frame_err), 64'd1);
    for (int i = 1; i < 5; i++) begin
      check_eq($sformatf("ovf_drain%0d", i), 64'(recv_msg), 64'(i));
      pop_rx();
    end
    check_eq("ovf_drained", 64'(recv_val), 64'd0);

    // Reset in mid-frame, released with cs still low
    push_tx(32'h55);
    spi_frame({2'b10, 32'h77}, PKT_W, rx);
    tick(6);
    check_eq("mid_pre_val", 64'(recv_val), 64'd1);
    cs = 1'b0;
    tick(5);
    spi_bits({2'b11, 32'h12345678}, 10, rx);
    reset = 1'b0;
    #1;
    check_eq("mid_recv_val", 64'(recv_val), 64'd0);
    check_eq("mid_recv_msg", 64'(recv_msg), 64'd0);
    check_eq("mid_miso", 64'(miso), 64'd0);
    check_eq("mid_parity", 64'(parity), 64'd0);
    check_eq("mid_overflow", 64'(overflow), 64'd0);
    check_eq("mid_frame_err", 64'(frame_err), 64'd0);
    check_eq("mid_send_rdy", 64'(send_rdy), 64'd0);
    tick(2);
    reset = 1'b1;
    tick(8);
    check_eq("mid_ferr_pre", 64'(frame_err), 64'd0);
    check_eq("mid_send_rdy_up", 64'(send_rdy), 64'd1);
    cs = 1'b1;
    tick(6);
    check_eq("mid_ferr_post", 64'(frame_err), 64'd1);
    check_eq("mid_rx_empty", 64'(recv_val), 64'd0);
    spi_frame({2'b00, 32'h0}, PKT_W, rx);
    check_eq("mid_tx_empty", 64'(rx), 64'h2_0000_0000);
    tick(6);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
